// File: rtl/seq_ctrl.sv
// ---------------------------------------------------------------------------
// seq_ctrl: eight-phase Moore sequence controller for the VeriRISC datapath.
// The only flops are the phase register. Every strobe is decoded
// combinationally from the current phase, the IR opcode and the
// accumulator zero flag.
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset
//   opcode   in   [2:0] IR opcode (HLT,SKZ,ADD,AND,XOR,LDA,STO,JMP = 0..7)
//   zero     in   accumulator == 0
//   mem_rd   out  memory read strobe
//   load_ir  out  instruction-register load
//   halt     out  processor halted
//   inc_pc   out  program-counter increment
//   load_ac  out  accumulator load
//   load_pc  out  program-counter load (jump)
//   mem_wr   out  memory write strobe
//   data_e   out  accumulator drives the data bus
//   sel      out  address-mux select, 1 = PC, 0 = IR operand
//
// Parameter
//   HALT_STICKY  1: park in OP_ADDR on HLT until reset
//                0: halt is a one-cycle pulse and sequencing continues
// ---------------------------------------------------------------------------
module seq_ctrl #(
  parameter bit HALT_STICKY = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic       mem_rd,
  output logic       load_ir,
  output logic       halt,
  output logic       inc_pc,
  output logic       load_ac,
  output logic       load_pc,
  output logic       mem_wr,
  output logic       data_e,
  output logic       sel
);

  localparam int unsigned StateW  = 3;
  localparam int unsigned OpcodeW = 3;

  typedef enum logic [StateW-1:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } state_e;

  localparam logic [OpcodeW-1:0] OP_HLT = 3'd0;
  localparam logic [OpcodeW-1:0] OP_SKZ = 3'd1;
  localparam logic [OpcodeW-1:0] OP_ADD = 3'd2;
  localparam logic [OpcodeW-1:0] OP_AND = 3'd3;
  localparam logic [OpcodeW-1:0] OP_XOR = 3'd4;
  localparam logic [OpcodeW-1:0] OP_LDA = 3'd5;
  localparam logic [OpcodeW-1:0] OP_STO = 3'd6;
  localparam logic [OpcodeW-1:0] OP_JMP = 3'd7;

  state_e state_q, state_d;

  logic is_hlt_c;
  logic is_skz_c;
  logic is_sto_c;
  logic is_jmp_c;
  logic alu_op_c;

  // Opcode decode shared by next-state and output logic
  always_comb begin
    is_hlt_c = (opcode == OP_HLT);
    is_skz_c = (opcode == OP_SKZ);
    is_sto_c = (opcode == OP_STO);
    is_jmp_c = (opcode == OP_JMP);
    alu_op_c = (opcode == OP_ADD) || (opcode == OP_AND) ||
               (opcode == OP_XOR) || (opcode == OP_LDA);
  end

  // Phase register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INST_ADDR;
    end else begin
      state_q <= state_d;
    end
  end

  // Next phase: strict ring, except a sticky HLT parks in OP_ADDR
  always_comb begin
    state_d = INST_ADDR;
    case (state_q)
      INST_ADDR:  state_d = INST_FETCH;
      INST_FETCH: state_d = INST_LOAD;
      INST_LOAD:  state_d = IDLE;
      IDLE:       state_d = OP_ADDR;
      OP_ADDR:    state_d = (HALT_STICKY && is_hlt_c) ? OP_ADDR : OP_FETCH;
      OP_FETCH:   state_d = ALU_OP;
      ALU_OP:     state_d = STORE;
      STORE:      state_d = INST_ADDR;
      default:    state_d = INST_ADDR;
    endcase
  end

  // Strobe decode from current phase, opcode and zero
  always_comb begin
    mem_rd  = 1'b0;
    load_ir = 1'b0;
    halt    = 1'b0;
    inc_pc  = 1'b0;
    load_ac = 1'b0;
    load_pc = 1'b0;
    mem_wr  = 1'b0;
    data_e  = 1'b0;
    sel     = 1'b0;
    case (state_q)
      INST_ADDR: begin
        sel = 1'b1;
      end
      INST_FETCH: begin
        sel    = 1'b1;
        mem_rd = 1'b1;
      end
      INST_LOAD, IDLE: begin
        sel     = 1'b1;
        mem_rd  = 1'b1;
        load_ir = 1'b1;
      end
      OP_ADDR: begin
        halt   = is_hlt_c;
        inc_pc = !is_hlt_c;
      end
      OP_FETCH: begin
        mem_rd = alu_op_c;
      end
      ALU_OP: begin
        mem_rd  = alu_op_c;
        inc_pc  = is_skz_c && zero;
        load_pc = is_jmp_c;
        data_e  = is_sto_c;
      end
      STORE: begin
        mem_rd  = alu_op_c;
        load_ac = alu_op_c;
        load_pc = is_jmp_c;
        inc_pc  = is_jmp_c;
        mem_wr  = is_sto_c;
        data_e  = is_sto_c;
      end
      default: begin
        sel = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seq_ctrl: directed scoreboard bench for seq_ctrl. Two instances share
// stimulus: dut_s (HALT_STICKY=1) and dut_n (HALT_STICKY=0). Expected strobe
// patterns are written as per-signal 8-bit cycle masks (bit c = phase c).
// ---------------------------------------------------------------------------
module tb_seq_ctrl;

  localparam logic [2:0] HLT = 3'd0, SKZ = 3'd1, ADD = 3'd2, AND = 3'd3,
                         XOR = 3'd4, LDA = 3'd5, STO = 3'd6, JMP = 3'd7;

  typedef struct packed {
    logic [7:0] sel, mem_rd, load_ir, halt, inc_pc, load_ac, load_pc,
                mem_wr, data_e;
  } masks_t;

  typedef struct {
    string      tag;
    logic [8:0] exp;
  } sb_t;

  logic       clk;
  logic       rst;
  logic [2:0] opcode;
  logic       zero;

  logic mem_rd_s, load_ir_s, halt_s, inc_pc_s, load_ac_s, load_pc_s,
        mem_wr_s, data_e_s, sel_s;
  logic mem_rd_n, load_ir_n, halt_n, inc_pc_n, load_ac_n, load_pc_n,
        mem_wr_n, data_e_n, sel_n;

  sb_t q_s[$];
  sb_t q_n[$];
  int  n_cmp = 0;
  int  n_err = 0;

  seq_ctrl #(.HALT_STICKY(1'b1)) dut_s (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
    .mem_rd(mem_rd_s), .load_ir(load_ir_s), .halt(halt_s),
    .inc_pc(inc_pc_s), .load_ac(load_ac_s), .load_pc(load_pc_s),
    .mem_wr(mem_wr_s), .data_e(data_e_s), .sel(sel_s)
  );

  seq_ctrl #(.HALT_STICKY(1'b0)) dut_n (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
    .mem_rd(mem_rd_n), .load_ir(load_ir_n), .halt(halt_n),
    .inc_pc(inc_pc_n), .load_ac(load_ac_n), .load_pc(load_pc_n),
    .mem_wr(mem_wr_n), .data_e(data_e_n), .sel(sel_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Fetch portion common to every instruction
  function automatic masks_t base_masks();
    masks_t m;
    m         = '0;
    m.sel     = 8'h0F;
    m.mem_rd  = 8'h0E;
    m.load_ir = 8'h0C;
    return m;
  endfunction

  // Expected vector at cycle c; cycles past 7 reuse the cycle-7 column
  function automatic logic [8:0] vec_at(input masks_t m, input int c);
    int k;
    k = (c > 7) ? 7 : c;
    return {m.sel[k], m.mem_rd[k], m.load_ir[k], m.halt[k], m.inc_pc[k],
            m.load_ac[k], m.load_pc[k], m.mem_wr[k], m.data_e[k]};
  endfunction

  task automatic compare_s();
    sb_t e;
    logic [8:0] obs;
    obs = {sel_s, mem_rd_s, load_ir_s, halt_s, inc_pc_s, load_ac_s,
           load_pc_s, mem_wr_s, data_e_s};
    e = q_s.pop_front();
    n_cmp++;
    assert (obs === e.exp) else begin
      n_err++;
      $error("FAIL %s sticky obs=%b exp=%b", e.tag, obs, e.exp);
    end
  endtask

  task automatic compare_n();
    sb_t e;
    logic [8:0] obs;
    obs = {sel_n, mem_rd_n, load_ir_n, halt_n, inc_pc_n, load_ac_n,
           load_pc_n, mem_wr_n, data_e_n};
    e = q_n.pop_front();
    n_cmp++;
    assert (obs === e.exp) else begin
      n_err++;
      $error("FAIL %s nonsticky obs=%b exp=%b", e.tag, obs, e.exp);
    end
  endtask

  // Run ncyc phases from the current negedge; nonsticky checked for c < n_chk.
  // If rst_last, rst is raised during the final checked phase.
  task automatic run_instr(input string name, input logic [2:0] op,
                           input logic z, input masks_t m_s,
                           input masks_t m_n, input int ncyc,
                           input int n_chk, input bit rst_last);
    sb_t e;
    opcode = op;
    zero   = z;
    for (int c = 0; c < ncyc; c++) begin
      e.tag = $sformatf("%s_c%0d", name, c);
      e.exp = vec_at(m_s, c);
      q_s.push_back(e);
      if (c < n_chk) begin
        e.exp = vec_at(m_n, c);
        q_n.push_back(e);
      end
      compare_s();
      if (c < n_chk) compare_n();
      if (rst_last && (c == ncyc - 1)) rst = 1'b1;
      @(negedge clk);
    end
    rst = 1'b0;
  endtask

  initial begin
    masks_t m, mh;
    rst    = 1'b1;
    opcode = ADD;
    zero   = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // ADD: reset state is cycle 0 of this instruction
    m = base_masks();
    m.mem_rd = 8'hEE; m.inc_pc = 8'h10; m.load_ac = 8'h80;
    run_instr("add", ADD, 1'b0, m, m, 8, 8, 1'b0);
    run_instr("and_z", AND, 1'b1, m, m, 8, 8, 1'b0);
    run_instr("xor", XOR, 1'b0, m, m, 8, 8, 1'b0);
    run_instr("lda", LDA, 1'b1, m, m, 8, 8, 1'b0);

    // STO
    m = base_masks();
    m.inc_pc = 8'h10; m.data_e = 8'hC0; m.mem_wr = 8'h80;
    run_instr("sto", STO, 1'b0, m, m, 8, 8, 1'b0);

    // SKZ with and without zero
    m = base_masks();
    m.inc_pc = 8'h50;
    run_instr("skz_z1", SKZ, 1'b1, m, m, 8, 8, 1'b0);
    m.inc_pc = 8'h10;
    run_instr("skz_z0", SKZ, 1'b0, m, m, 8, 8, 1'b0);

    // JMP
    m = base_masks();
    m.load_pc = 8'hC0; m.inc_pc = 8'h90;
    run_instr("jmp", JMP, 1'b0, m, m, 8, 8, 1'b0);

    // HLT: sticky parks from cycle 4 for 20 cycles; nonsticky pulses once
    mh = base_masks();
    mh.halt = 8'hF0;
    m = base_masks();
    m.halt = 8'h10;
    run_instr("hlt", HLT, 1'b0, mh, m, 24, 8, 1'b1);

    // Back to INST_ADDR after reset out of the parked halt
    m = base_masks();
    m.mem_rd = 8'hEE; m.inc_pc = 8'h10; m.load_ac = 8'h80;
    run_instr("post_hlt_add", ADD, 1'b0, m, m, 8, 8, 1'b0);

    // Reset asserted while in ALU_OP of a STO
    m = base_masks();
    m.inc_pc = 8'h10; m.data_e = 8'hC0; m.mem_wr = 8'h80;
    run_instr("sto_mid", STO, 1'b0, m, m, 7, 7, 1'b1);
    run_instr("after_mid_rst", STO, 1'b0, m, m, 8, 8, 1'b0);

    n_cmp++;
    assert ((q_s.size() == 0) && (q_n.size() == 0)) else begin
      n_err++;
      $error("FAIL sb_drain obs=%0d/%0d exp=0/0", q_s.size(), q_n.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
